dpram_port_arbiter: RTL and testbench
=====================================

Name: dpram_port_arbiter

Overview:
- Shares one simple dual-port RAM (one write port, one registered read port, 1-cycle read latency) between two requesters.
- Two independent round-robin arbiters: one for the RAM write port, one for the read port.
- Read responses are routed back to the granted requester using a registered tag.
- Sits between compiler-generated method FSMs and a shared array RAM instance.

Parameters:
- WIDTH, 32, data word width (must match the RAM).
- DEPTH, 10, number of address bits actually used (low DEPTH bits of each address).
- WORDS, 1024, RAM word count; exported on length.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- length  out  32  constant WORDS.
- r0_req / r1_req  in  1  read request from requester 0 / 1.
- r0_addr / r1_addr  in  32  read address.
- r0_gnt / r1_gnt  out  1  read grant, combinational, same cycle as request.
- r0_rvalid / r1_rvalid  out  1  read data valid, one-cycle pulse.
- r0_rdata / r1_rdata  out  WIDTH  read data.
- w0_req / w1_req  in  1  write request.
- w0_addr / w1_addr  in  32  write address.
- w0_din / w1_din  in  WIDTH  write data.
- w0_gnt / w1_gnt  out  1  write grant, combinational.
- ram_raddress  out  32  RAM read address.
- ram_waddress  out  32  RAM write address.
- ram_din  out  WIDTH  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable; high whenever a read is granted.
- ram_dout  in  WIDTH  RAM registered read data.

Behaviour:
- Reset values (reset=0 at an edge):
  - rvalid outputs = 0; response tag register = 0.
  - Both round-robin pointers = "last granted = 1", so requester 0 wins first.
  - Bypass registers = 0.
  - gnt outputs are combinational but forced 0 while reset=0.
  - ram_we and ram_oe = 0 while reset=0.
- Handshake:
  - A requester holds req, addr and din stable until it sees gnt high in the same cycle.
  - The transaction completes at that clock edge; req may drop or change next cycle.
- Arbitration, per channel (read and write separately):
  - Only one requester active: it is granted.
  - Both active: grant the one not granted last.
  - The pointer updates only on a grant cycle.
  - No grant if neither requests.
  - Each channel grants at most 1 per cycle. The read and write channels may both grant in the same cycle.
- Write path in grant cycle T:
  - ram_we = 1.
  - ram_waddress = granted addr, ram_din = granted din (both muxed combinationally).
  - When idle: ram_we = 0, addresses/data hold the requester-0 values (don't care).
- Read path:
  - Grant at cycle T: ram_raddress = granted addr; tag register captures {valid=1, id}.
  - Cycle T+1: rX_rvalid = 1 for tagged id only; rX_rdata = ram_dout.
  - Non-tagged rdata = 0.
  - Latency is exactly 1 cycle. Back-to-back reads give a response every cycle.
- Address use: only [DEPTH-1:0] is significant. Upper bits pass through untouched; addresses ≥ WORDS alias (no error).
- Simultaneous read and write, same low-DEPTH address, same cycle: read returns OLD data (read-before-write), unless bypass is enabled.
- Reset mid-operation: a pending read response is dropped (no rvalid at T+1); any write granted in the reset cycle is not performed.

Optional Feature:
- Macro DPRAM_ARB_RAW_BYPASS_EN.
- Defined:
  - When read and write are granted in the same cycle to equal addr[DEPTH-1:0], register hit=1 and the write data.
  - At T+1, rdata of the tagged requester = the captured write data (NEW value).
- Undefined: no bypass registers; OLD value returned.

Decomposition:
- Shared package dpram_arb_pkg:
  - requester-id typedef (1 bit).
  - tag struct {valid, id}.
  - localparam NUM_REQ = 2.
- Sub-module rr_arb2:
  - 2-input round-robin arbiter with registered last-grant pointer.
  - Instanced twice (read and write channels).

Test Plan:
- After reset, w0_req and w1_req both high, addr 5/6, din 0xA/0xB, held 2 cycles -> w0_gnt cycle 1, w1_gnt cycle 2; mem[5]=0xA, mem[6]=0xB.
- r0_req=r1_req=1 continuously, addrs 5/6 -> grants alternate 0,1,0,1; each r*_rvalid one cycle after its grant with 0xA / 0xB; no cycle with both rvalid.
- Same cycle: w0 write addr 7 = 0x55 (old 0x11) and r1 read addr 7 -> r1_rdata=0x11 without the macro, 0x55 with DPRAM_ARB_RAW_BYPASS_EN.
- Read granted, then reset=0 on next edge -> no rvalid afterwards; after release, first contended grant goes to requester 0.
- Write to addr 0x400 with DEPTH=10 -> ram_waddress=0x400, aliases word 0; read of addr 0 returns the written value; length=1024.
- Only r1_req held 4 cycles -> granted every cycle, 4 consecutive rvalid pulses on r1, none on r0.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// Shared types for the dual-port RAM arbiter: requester id, read response tag
// and requester count.
package dpram_arb_pkg;

   localparam int NUM_REQ = 2;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

endpackage

// File: rtl/dpram_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The last-grant pointer only moves on a grant
// cycle. Grants are combinational and held low while reset is asserted.
module rr_arb2
   import dpram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output req_id_t    gnt_id
);

   req_id_t last_id;

   always_comb begin
      gnt = 2'b00;
      if (reset) begin
         if (req[0] && req[1]) begin
            gnt = last_id ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
      gnt_id = gnt[1];
   end

   // Reset to "requester 1 went last" so requester 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_id <= 1'b1;
      end else if (|gnt) begin
         last_id <= gnt_id;
      end
   end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one simple dual-port RAM between two requesters, with independent
// round-robin read and write arbiters. Optional DPRAM_ARB_RAW_BYPASS_EN returns
// new data for same-cycle read/write to the same address.
module dpram_port_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 10,
   parameter int WORDS = 1024
) (
   input  logic             clk,
   input  logic             reset,
   output logic [31:0]      length,
   input  logic             r0_req,
   input  logic             r1_req,
   input  logic [31:0]      r0_addr,
   input  logic [31:0]      r1_addr,
   output logic             r0_gnt,
   output logic             r1_gnt,
   output logic             r0_rvalid,
   output logic             r1_rvalid,
   output logic [WIDTH-1:0] r0_rdata,
   output logic [WIDTH-1:0] r1_rdata,
   input  logic             w0_req,
   input  logic             w1_req,
   input  logic [31:0]      w0_addr,
   input  logic [31:0]      w1_addr,
   input  logic [WIDTH-1:0] w0_din,
   input  logic [WIDTH-1:0] w1_din,
   output logic             w0_gnt,
   output logic             w1_gnt,
   output logic [31:0]      ram_raddress,
   output logic [31:0]      ram_waddress,
   output logic [WIDTH-1:0] ram_din,
   output logic             ram_we,
   output logic             ram_oe,
   input  logic [WIDTH-1:0] ram_dout
);

   logic [NUM_REQ-1:0] rd_req, rd_gnt, wr_req, wr_gnt;
   req_id_t            rd_id, wr_id;
   rd_tag_t            tag;
   logic [WIDTH-1:0]   rd_word;

   assign length = 32'(WORDS);
   assign rd_req = {r1_req, r0_req};
   assign wr_req = {w1_req, w0_req};

   rr_arb2 u_rd_arb (.clk(clk), .reset(reset), .req(rd_req), .gnt(rd_gnt), .gnt_id(rd_id));
   rr_arb2 u_wr_arb (.clk(clk), .reset(reset), .req(wr_req), .gnt(wr_gnt), .gnt_id(wr_id));

   assign r0_gnt = rd_gnt[0];
   assign r1_gnt = rd_gnt[1];
   assign w0_gnt = wr_gnt[0];
   assign w1_gnt = wr_gnt[1];

   assign ram_oe       = |rd_gnt;
   assign ram_we       = |wr_gnt;
   assign ram_raddress = rd_gnt[1] ? r1_addr : r0_addr;
   assign ram_waddress = wr_gnt[1] ? w1_addr : w0_addr;
   assign ram_din      = wr_gnt[1] ? w1_din  : w0_din;

   always_ff @(posedge clk) begin
      if (!reset) begin
         tag <= '0;
      end else begin
         tag.valid <= |rd_gnt;
         tag.id    <= rd_id;
      end
   end

`ifdef DPRAM_ARB_RAW_BYPASS_EN
   logic             byp_hit;
   logic [WIDTH-1:0] byp_data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         byp_hit  <= 1'b0;
         byp_data <= '0;
      end else begin
         byp_hit  <= ram_oe && ram_we &&
                     (ram_raddress[DEPTH-1:0] == ram_waddress[DEPTH-1:0]);
         byp_data <= ram_din;
      end
   end

   assign rd_word = byp_hit ? byp_data : ram_dout;
`else
   assign rd_word = ram_dout;
`endif

   // Gated by reset so a response pending when reset arrives is dropped.
   assign r0_rvalid = reset && tag.valid && (tag.id == 1'b0);
   assign r1_rvalid = reset && tag.valid && (tag.id == 1'b1);
   assign r0_rdata  = r0_rvalid ? rd_word : '0;
   assign r1_rdata  = r1_rvalid ? rd_word : '0;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural registered-read RAM.
module tb_dpram_port_arbiter;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      length;
   logic             r0_req, r1_req;
   logic [31:0]      r0_addr, r1_addr;
   logic             r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
   logic [WIDTH-1:0] r0_rdata, r1_rdata;
   logic             w0_req, w1_req;
   logic [31:0]      w0_addr, w1_addr;
   logic [WIDTH-1:0] w0_din, w1_din;
   logic             w0_gnt, w1_gnt;
   logic [31:0]      ram_raddress, ram_waddress;
   logic [WIDTH-1:0] ram_din, ram_dout;
   logic             ram_we, ram_oe;

   logic [WIDTH-1:0] mem [0:1023];
   int               checks = 0;
   int               errors = 0;

   always #5 clk = ~clk;

   dpram_port_arbiter dut (
      .clk(clk), .reset(reset), .length(length),
      .r0_req(r0_req), .r1_req(r1_req), .r0_addr(r0_addr), .r1_addr(r1_addr),
      .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
      .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
      .w0_req(w0_req), .w1_req(w1_req), .w0_addr(w0_addr), .w1_addr(w1_addr),
      .w0_din(w0_din), .w1_din(w1_din), .w0_gnt(w0_gnt), .w1_gnt(w1_gnt),
      .ram_raddress(ram_raddress), .ram_waddress(ram_waddress), .ram_din(ram_din),
      .ram_we(ram_we), .ram_oe(ram_oe), .ram_dout(ram_dout)
   );

   // RAM model: registered read, read-before-write on the same address.
   always @(posedge clk) begin
      if (ram_oe) ram_dout <= mem[ram_raddress[9:0]];
      if (ram_we) mem[ram_waddress[9:0]] <= ram_din;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1-2 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      r0_req = 0; r1_req = 0; w0_req = 0; w1_req = 0;
   endtask

   logic [31:0] exp_raw;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      ram_dout = '0;
      idle();
      r0_addr = 0; r1_addr = 0; w0_addr = 0; w1_addr = 0; w0_din = 0; w1_din = 0;
      reset = 1'b0;
      step(); step();

      // Requests during reset must not be granted.
      w0_req = 1; r0_req = 1; #1;
      check("rst_w0_gnt", 32'(w0_gnt), 0);
      check("rst_ram_we", 32'(ram_we), 0);
      check("rst_ram_oe", 32'(ram_oe), 0);
      check("rst_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 0);
      check("length", length, 32'd1024);
      idle();
      step();
      reset = 1'b1;

      // Contended writes: requester 0 first, then 1.
      w0_req = 1; w0_addr = 5; w0_din = 32'hA;
      w1_req = 1; w1_addr = 6; w1_din = 32'hB; #1;
      check("wr1_gnt", {30'd0, w1_gnt, w0_gnt}, 32'b01);
      check("wr1_addr", ram_waddress, 5);
      check("wr1_din", ram_din, 32'hA);
      step();
      w0_req = 0; #1;
      check("wr2_gnt", {30'd0, w1_gnt, w0_gnt}, 32'b10);
      check("wr2_addr", ram_waddress, 6);
      step();
      idle();
      check("mem5", mem[5], 32'hA);
      check("mem6", mem[6], 32'hB);

      // Contended reads alternate 0,1,0,1 with one-cycle-later responses.
      r0_req = 1; r0_addr = 5; r1_req = 1; r1_addr = 6;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) idle();
         #1;
         if (k < 4) check("rd_alt_gnt", {30'd0, r1_gnt, r0_gnt}, (k % 2 == 0) ? 32'b01 : 32'b10);
         if (k > 0) begin
            check("rd_alt_rvalid", {30'd0, r1_rvalid, r0_rvalid}, ((k - 1) % 2 == 0) ? 32'b01 : 32'b10);
            check("rd_alt_rdata", ((k - 1) % 2 == 0) ? r0_rdata : r1_rdata,
                  ((k - 1) % 2 == 0) ? 32'hA : 32'hB);
         end
         step();
      end

      // Same-cycle read and write to address 7.
      w0_req = 1; w0_addr = 7; w0_din = 32'h11;
      step();
      w0_din = 32'h55; r1_req = 1; r1_addr = 7; #1;
      check("raw_gnt", {28'd0, w1_gnt, w0_gnt, r1_gnt, r0_gnt}, 32'b0110);
      step();
      idle(); #1;
`ifdef DPRAM_ARB_RAW_BYPASS_EN
      exp_raw = 32'h55;
`else
      exp_raw = 32'h11;
`endif
      check("raw_rvalid", 32'(r1_rvalid), 1);
      check("raw_rdata", r1_rdata, exp_raw);
      check("raw_r0_rdata", r0_rdata, 0);
      r1_req = 1; step();
      idle(); #1;
      check("raw_after", r1_rdata, 32'h55);
      step();

      // Read granted, then reset: the response is dropped.
      r0_req = 1; r0_addr = 5; #1;
      check("rstmid_gnt", 32'(r0_gnt), 1);
      step();
      idle(); reset = 1'b0; #1;
      check("rstmid_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 0);
      step();
      check("rstmid_rvalid2", {30'd0, r1_rvalid, r0_rvalid}, 0);
      reset = 1'b1;
      r0_req = 1; r0_addr = 5; r1_req = 1; r1_addr = 6;
      w0_req = 1; w0_addr = 8; w0_din = 32'h88; w1_req = 1; w1_addr = 9; w1_din = 32'h99; #1;
      check("post_rst_rgnt", {30'd0, r1_gnt, r0_gnt}, 32'b01);
      check("post_rst_wgnt", {30'd0, w1_gnt, w0_gnt}, 32'b01);
      step();
      idle(); #1;
      check("post_rst_rdata", r0_rdata, 32'hA);
      step();

      // Address aliasing above WORDS.
      w0_req = 1; w0_addr = 32'h400; w0_din = 32'h77; #1;
      check("alias_waddr", ram_waddress, 32'h400);
      step();
      idle(); r0_req = 1; r0_addr = 0; #1;
      check("alias_raddr", ram_raddress, 0);
      step();
      idle(); #1;
      check("alias_rdata", r0_rdata, 32'h77);
      step();

      // Single requester streaming four reads.
      r1_req = 1; r1_addr = 6;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) idle();
         #1;
         if (k < 4) check("stream_gnt", 32'(r1_gnt), 1);
         check("stream_r0_rvalid", 32'(r0_rvalid), 0);
         check("stream_r1_rvalid", 32'(r1_rvalid), (k >= 1 && k <= 4) ? 1 : 0);
         if (k >= 1 && k <= 4) check("stream_rdata", r1_rdata, 32'hB);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
